mux_n_1_scan: RTL and testbench
===============================

MUX_N_1_SCAN -- requirements
Module: mux_n_1_scan

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of input channels (2..16).
REQ-002 The block SHALL have parameter W, default 1, giving the bit width of each channel.
REQ-003 The block SHALL have parameter DWELL, default 4, giving the cycles spent on each channel in scan mode (1..255).
REQ-004 The block SHALL have localparam SW = clog2(N_CH), giving the select/channel index width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in, input, N_CH*W bits: packed channel data, channel k at bits [k*W+W-1 : k*W].
REQ-008 The block SHALL have port sel, input, SW bits: channel index used in manual mode.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = manual, 1 = auto-scan.
REQ-010 The block SHALL have port en, input, 1 bit: 1 = operate, 0 = hold/idle.
REQ-011 The block SHALL have port y, output, W bits: registered selected channel data.
REQ-012 The block SHALL have port y_valid, output, 1 bit: y holds valid data for channel ch.
REQ-013 The block SHALL have port ch, output, SW bits: registered index of the channel currently driven on y.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when scan wraps from channel N_CH-1 to 0.
REQ-015 The block SHALL have port sel_err, output, 1 bit: registered flag set while manual sel >= N_CH.

Function
REQ-016 The block SHALL implement FSM states IDLE, MAN and SCAN.
REQ-017 FSM transitions SHALL be evaluated every cycle:
- en=0 → IDLE.
- en=1, mode=0 → MAN.
- en=1, mode=1 → SCAN.
REQ-018 All outputs SHALL be registered, with latency of exactly 1 cycle from in/sel/mode/en to y/y_valid/ch/sel_err.
REQ-019 In MAN state with sel < N_CH, the next cycle SHALL give ch = sel, y = in[sel], y_valid = 1 and sel_err = 0.
REQ-020 In MAN state with sel >= N_CH (non-power-of-2 N_CH), the next cycle SHALL give ch held, y = 0, y_valid = 0 and sel_err = 1.
REQ-021 In SCAN state, a dwell counter SHALL count 0..DWELL-1.
- At DWELL-1: counter returns to 0 and ch advances by 1.
- Otherwise: ch is held.
- y SHALL track in[ch] live every cycle and y_valid SHALL be 1.
REQ-022 Scan wrap-around: when ch = N_CH-1 and the counter is at DWELL-1, the next ch SHALL be 0 and wrap SHALL pulse high for exactly that one cycle.
REQ-023 With DWELL = 1, ch SHALL advance every cycle.
REQ-024 On entry to SCAN from MAN or IDLE, scanning SHALL start at the current ch with the dwell counter at 0.
REQ-025 On SCAN→MAN, the next cycle SHALL load ch from sel and clear the dwell counter.
REQ-026 In IDLE, ch SHALL be held, the dwell counter held, y held, y_valid = 0 and wrap = 0.
REQ-027 On leaving IDLE back to SCAN, the block SHALL resume from the held ch and the counter SHALL reset to 0.
REQ-028 sel SHALL be ignored in SCAN and IDLE; sel_err SHALL be 0 outside MAN.
REQ-029 The dwell counter width SHALL be 8 bits; ch increment SHALL be modulo N_CH, not modulo 2^SW.

Reset
REQ-030 On rst_n = 0, asynchronously: state = IDLE, ch = 0, dwell counter = 0, y = 0, y_valid = 0, wrap = 0, sel_err = 0.
REQ-031 Reset asserted mid-scan SHALL abort immediately. After release, the first active edge SHALL apply REQ-017 from ch = 0.
REQ-032 Reset deassertion SHALL take effect on the first rising clk edge after rst_n goes high; no output changes before it.

Verification
REQ-033 Manual sweep: N_CH=4, W=1, in=4'b1000, en=1, mode=0, sel=0,1,2,3, one per cycle → y = 0,0,0,1 one cycle later; y_valid=1; ch follows sel.
REQ-034 Scan with wrap: N_CH=4, DWELL=2, in=4'b0101, en=1, mode=1 from reset → ch = 0,0,1,1,2,2,3,3,0; y = 1,1,0,0,1,1,0,0,1; wrap high only on the cycle ch returns to 0.
REQ-035 Out-of-range select: N_CH=3, mode=0, sel=3 → y=0, y_valid=0, sel_err=1, ch held; then sel=2 → sel_err=0, ch=2.
REQ-036 Freeze and resume: scanning at ch=2, drop en for 5 cycles → ch stays 2, y_valid=0, wrap=0; raise en → ch=2 for a full DWELL, then 3.
REQ-037 Mode switch and reset: scanning at ch=1, set mode=0, sel=3 → ch=3 next cycle. Assert rst_n=0 mid-cycle → all outputs 0 at once, without waiting for clk.
REQ-038 Parameter sweep: N_CH ∈ {2,4,5,8}, W ∈ {1,8}, DWELL ∈ {1,3}, random in/sel/mode/en for 2000 cycles, checked against a cycle-accurate model of REQ-016..REQ-029.

Source files
------------

// File: rtl/mux_n_1_scan.sv
// N-to-1 channel multiplexer with a manual select mode and an auto-scan mode.
// All outputs are registered; scan mode stays on each channel for DWELL cycles.
module mux_n_1_scan #(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in,
    input  logic [SW-1:0]     sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      y,
    output logic              y_valid,
    output logic [SW-1:0]     ch,
    output logic              wrap,
    output logic              sel_err
);

    localparam int            NSLOT      = 2 ** SW;
    localparam logic [SW:0]   N_CH_X     = (SW + 1)'(N_CH);
    localparam logic [SW-1:0] LAST_CH    = SW'(N_CH - 1);
    localparam logic [7:0]    DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] ch_reg, ch_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [W-1:0]  y_reg, y_next;
    logic          y_valid_reg, y_valid_next;
    logic          wrap_reg, wrap_next;
    logic          sel_err_reg, sel_err_next;
    logic          sel_ok;

    // Pad the channel table to a power of two so any index is a legal read.
    logic [W-1:0] chan [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_chan
            if (gi < N_CH) begin : g_used
                assign chan[gi] = in[gi*W +: W];
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
    endgenerate

    assign sel_ok = ({1'b0, sel} < N_CH_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ch_reg      <= '0;
            cnt_reg     <= '0;
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
            wrap_reg    <= 1'b0;
            sel_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ch_reg      <= ch_next;
            cnt_reg     <= cnt_next;
            y_reg       <= y_next;
            y_valid_reg <= y_valid_next;
            wrap_reg    <= wrap_next;
            sel_err_reg <= sel_err_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (en) begin
            state_next = mode ? SCAN : MAN;
        end
    end

    // Outputs are computed for the state being entered, giving one cycle of latency.
    always_comb begin
        ch_next      = ch_reg;
        cnt_next     = cnt_reg;
        y_next       = y_reg;
        y_valid_next = 1'b0;
        wrap_next    = 1'b0;
        sel_err_next = 1'b0;
        case (state_next)
            MAN: begin
                cnt_next = '0;
                if (sel_ok) begin
                    ch_next      = sel;
                    y_next       = chan[sel];
                    y_valid_next = 1'b1;
                end else begin
                    y_next       = '0;
                    sel_err_next = 1'b1;
                end
            end
            SCAN: begin
                if (state_reg != SCAN) begin
                    cnt_next = '0;
                end else if (cnt_reg == DWELL_LAST) begin
                    cnt_next = '0;
                    if (ch_reg == LAST_CH) begin
                        ch_next   = '0;
                        wrap_next = 1'b1;
                    end else begin
                        ch_next = ch_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
                y_next       = chan[ch_next];
                y_valid_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign ch      = ch_reg;
    assign wrap    = wrap_reg;
    assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_mux_n_1_scan.sv
// Directed scenarios on small instances plus a randomized multi-configuration sweep
// checked against a cycle-level behavioural model.
module tb_mux_n_1_scan;

    localparam int NCFG = 6;

    function automatic int cfg_n(input int i);
        case (i)
            0: return 2;
            1: return 4;
            2: return 5;
            3: return 8;
            4: return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_w(input int i);
        case (i)
            0: return 1;
            1: return 8;
            2: return 8;
            3: return 1;
            4: return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_d(input int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 1;
            3: return 3;
            4: return 3;
            default: return 1;
        endcase
    endfunction

    logic clk;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s value=%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed instance: 4 channels, 1 bit, dwell 2
    logic       a_rst_n, a_mode, a_en, a_y, a_yv, a_wrap, a_serr;
    logic [3:0] a_in;
    logic [1:0] a_sel, a_ch;

    mux_n_1_scan #(.N_CH(4), .W(1), .DWELL(2)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .in(a_in), .sel(a_sel), .mode(a_mode), .en(a_en),
        .y(a_y), .y_valid(a_yv), .ch(a_ch), .wrap(a_wrap), .sel_err(a_serr)
    );

    // Directed instance: 3 channels, exercising out-of-range select
    logic       b_rst_n, b_mode, b_en, b_y, b_yv, b_wrap, b_serr;
    logic [2:0] b_in;
    logic [1:0] b_sel, b_ch;

    mux_n_1_scan #(.N_CH(3), .W(1), .DWELL(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in(b_in), .sel(b_sel), .mode(b_mode), .en(b_en),
        .y(b_y), .y_valid(b_yv), .ch(b_ch), .wrap(b_wrap), .sel_err(b_serr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCFG; gi++) begin : g_rnd
            localparam int N  = cfg_n(gi);
            localparam int W  = cfg_w(gi);
            localparam int D  = cfg_d(gi);
            localparam int SW = $clog2(N);
            localparam int IW = N * W;

            logic          r_rst_n, r_mode, r_en, r_yv, r_wrap, r_serr;
            logic [IW-1:0] r_in;
            logic [SW-1:0] r_sel, r_ch;
            logic [W-1:0]  r_y;

            mux_n_1_scan #(.N_CH(N), .W(W), .DWELL(D)) dut (
                .clk(clk), .rst_n(r_rst_n), .in(r_in), .sel(r_sel), .mode(r_mode), .en(r_en),
                .y(r_y), .y_valid(r_yv), .ch(r_ch), .wrap(r_wrap), .sel_err(r_serr)
            );

            // Model: current channel, cycles already spent on it, and whether last cycle scanned
            int           m_ch, m_spent;
            bit           m_scan, m_yv, m_wrap, m_serr;
            logic [W-1:0] m_y;
            string        tg;

            initial begin
                tg      = $sformatf("rnd%0d_N%0d_W%0d_D%0d", gi, N, W, D);
                r_rst_n = 1'b0;
                r_en    = 1'b0;
                r_mode  = 1'b0;
                r_sel   = '0;
                r_in    = '0;
                m_ch = 0; m_spent = 0; m_scan = 0; m_yv = 0; m_wrap = 0; m_serr = 0; m_y = '0;
                repeat (2) @(negedge clk);
                check_eq({tg, "_rst"}, 32'({r_y, r_yv, r_ch, r_wrap, r_serr}), 32'd0);
                r_rst_n = 1'b1;
                for (int c = 0; c < 2000; c++) begin
                    if ($urandom_range(0, 63) == 0) begin
                        r_rst_n = 1'b0;
                        #1;
                        m_ch = 0; m_spent = 0; m_scan = 0; m_yv = 0; m_wrap = 0; m_serr = 0; m_y = '0;
                        check_eq({tg, "_areset"}, 32'({r_y, r_yv, r_ch, r_wrap, r_serr}), 32'd0);
                        #1 r_rst_n = 1'b1;
                    end
                    r_in  = IW'({$urandom(), $urandom()});
                    r_sel = SW'($urandom_range(0, (2 ** SW) - 1));
                    r_en  = ($urandom_range(0, 99) < 85);
                    if ($urandom_range(0, 7) == 0) r_mode = ~r_mode;
                    @(posedge clk);
                    m_wrap = 0;
                    m_serr = 0;
                    if (!r_en) begin
                        m_yv   = 0;
                        m_scan = 0;
                    end else if (!r_mode) begin
                        m_scan  = 0;
                        m_spent = 0;
                        if (int'(r_sel) < N) begin
                            m_ch = int'(r_sel);
                            m_y  = r_in[m_ch*W +: W];
                            m_yv = 1;
                        end else begin
                            m_y    = '0;
                            m_yv   = 0;
                            m_serr = 1;
                        end
                    end else begin
                        if (!m_scan) begin
                            m_spent = 0;
                        end else if (m_spent + 1 >= D) begin
                            m_spent = 0;
                            m_wrap  = (m_ch == N - 1);
                            m_ch    = (m_ch + 1) % N;
                        end else begin
                            m_spent++;
                        end
                        m_scan = 1;
                        m_y    = r_in[m_ch*W +: W];
                        m_yv   = 1;
                    end
                    @(negedge clk);
                    check_eq(tg, 32'({r_y, r_yv, r_ch, r_wrap, r_serr}),
                             32'({m_y, m_yv, SW'(m_ch), m_wrap, m_serr}));
                end
                n_done++;
            end
        end
    endgenerate

    initial begin
        int ch_t [17];
        int y_t  [13];
        int waited;
        ch_t = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 0, 0, 0, 0};
        y_t  = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        a_rst_n = 1'b0; a_en = 1'b0; a_mode = 1'b0; a_sel = '0; a_in = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_mode = 1'b0; b_sel = '0; b_in = '0;
        repeat (2) @(negedge clk);
        check_eq("a_reset_state", 32'({a_y, a_yv, a_ch, a_wrap, a_serr}), 32'd0);
        check_eq("b_reset_state", 32'({b_y, b_yv, b_ch, b_wrap, b_serr}), 32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;

        // Manual sweep
        a_in = 4'b1000; a_en = 1'b1; a_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i);
            step();
            check_eq($sformatf("man_y_sel%0d", i), 32'(a_y), (i == 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("man_ch_sel%0d", i), 32'(a_ch), 32'(i));
            check_eq($sformatf("man_valid_sel%0d", i), 32'({a_yv, a_serr}), 32'b10);
        end

        // Scan with wrap, starting from reset
        a_rst_n = 1'b0;
        #1 a_rst_n = 1'b1;
        a_mode = 1'b1; a_in = 4'b0101;
        for (int i = 0; i < 13; i++) begin
            step();
            check_eq($sformatf("scan_ch_%0d", i), 32'(a_ch), 32'(ch_t[i]));
            check_eq($sformatf("scan_y_%0d", i), 32'(a_y), 32'(y_t[i]));
            check_eq($sformatf("scan_wrap_%0d", i), 32'({a_wrap, a_yv}), (i == 8) ? 32'b11 : 32'b01);
        end

        // Freeze at ch=2 and resume
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("idle_%0d", i), 32'({a_y, a_yv, a_ch, a_wrap, a_serr}), 32'b1_0_10_0_0);
        end
        a_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq($sformatf("resume_ch_%0d", i), 32'(a_ch), 32'((i < 2) ? 2 : (i < 4) ? 3 : (i < 6) ? 0 : 1));
            check_eq($sformatf("resume_wrap_%0d", i), 32'(a_wrap), (i == 4) ? 32'd1 : 32'd0);
        end

        // Scan to manual switch, then asynchronous reset mid-cycle
        a_mode = 1'b0; a_sel = 2'd3; a_in = 4'b1000;
        step();
        check_eq("switch_to_man", 32'({a_y, a_yv, a_ch, a_wrap, a_serr}), 32'b1_1_11_0_0);
        @(posedge clk);
        #2 a_rst_n = 1'b0;
        #1;
        check_eq("async_reset_now", 32'({a_y, a_yv, a_ch, a_wrap, a_serr}), 32'd0);
        @(negedge clk);
        a_rst_n = 1'b1;
        a_mode  = 1'b1;
        step();
        check_eq("post_reset_scan", 32'({a_y, a_yv, a_ch, a_wrap, a_serr}), 32'b0_1_00_0_0);

        // Out-of-range select on a 3-channel instance
        b_in = 3'b110; b_en = 1'b1; b_mode = 1'b0; b_sel = 2'd1;
        step();
        check_eq("oor_pre", 32'({b_y, b_yv, b_ch, b_wrap, b_serr}), 32'b1_1_01_0_0);
        b_sel = 2'd3;
        step();
        check_eq("oor_sel3", 32'({b_y, b_yv, b_ch, b_wrap, b_serr}), 32'b0_0_01_0_1);
        b_sel = 2'd2;
        step();
        check_eq("oor_sel2", 32'({b_y, b_yv, b_ch, b_wrap, b_serr}), 32'b1_1_10_0_0);
        b_mode = 1'b1; b_sel = 2'd3;
        step();
        check_eq("oor_scan_ignores_sel", 32'({b_yv, b_ch, b_serr}), 32'b1_10_0);

        waited = 0;
        while (n_done < NCFG && waited < 40000) begin
            @(posedge clk);
            waited++;
        end
        if (n_done < NCFG) check_eq("random_sweep_timeout", 32'(n_done), 32'(NCFG));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
